// File: rtl/rvseed_rd_arb_pkg.sv
// rvseed_rd_arb_pkg: shared definitions for the two-requester AXI read arbiter.
// Holds the FSM encoding, requester indices and the AR/R payload layout.
// Optional feature macro used by the arbiter files: RVSEED_ARB_RR_EN.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

package rvseed_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int REQ_IFU = 0;
    localparam int REQ_LSU = 1;

    localparam int AXI_ID_W    = `AXI_ID_WIDTH;
    localparam int AXI_ADDR_W  = `AXI_ADDR_WIDTH;
    localparam int AXI_LEN_W   = `AXI_LEN_WIDTH;
    localparam int AXI_SIZE_W  = `AXI_SIZE_WIDTH;
    localparam int AXI_BURST_W = `AXI_BURST_WIDTH;
    localparam int AXI_DATA_W  = `AXI_DATA_WIDTH;
    localparam int AXI_RESP_W  = `AXI_RESP_WIDTH;

    // AR payload packed as {id, addr, len, size, burst}
    localparam int AR_PLD_W     = AXI_ID_W + AXI_ADDR_W + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W;
    localparam int AR_BURST_OFF = 0;
    localparam int AR_SIZE_OFF  = AR_BURST_OFF + AXI_BURST_W;
    localparam int AR_LEN_OFF   = AR_SIZE_OFF + AXI_SIZE_W;
    localparam int AR_ADDR_OFF  = AR_LEN_OFF + AXI_LEN_W;
    localparam int AR_ID_OFF    = AR_ADDR_OFF + AXI_ADDR_W;

    // R payload packed as {id, data, resp, last}
    localparam int R_PLD_W     = AXI_ID_W + AXI_DATA_W + AXI_RESP_W + 1;
    localparam int R_LAST_OFF  = 0;
    localparam int R_RESP_OFF  = 1;
    localparam int R_DATA_OFF  = R_RESP_OFF + AXI_RESP_W;
    localparam int R_ID_OFF    = R_DATA_OFF + AXI_DATA_W;

    // One-hot encoding of a requester index
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rvseed_rd_arb_if.sv
// rvseed_rd_arb_if: requester-side and downstream-side read channel bundle.
// The arbiter uses the master modport; the environment uses the slave modport.
// Used with optional arbitration macro RVSEED_ARB_RR_EN (no effect on the bundle).

interface rvseed_rd_arb_if
    import rvseed_rd_arb_pkg::*;
#(
    parameter int AR_W = AR_PLD_W,
    parameter int R_W  = R_PLD_W
);
    logic [1:0]        m_arvalid;
    logic [1:0]        m_arready;
    logic [2*AR_W-1:0] m_ar_pld;
    logic [1:0]        m_rvalid;
    logic [1:0]        m_rready;
    logic [R_W-1:0]    m_r_pld;
    logic              s_arvalid;
    logic              s_arready;
    logic [AR_W-1:0]   s_ar_pld;
    logic              s_rvalid;
    logic              s_rready;
    logic [R_W-1:0]    s_r_pld;
    logic [1:0]        gnt;
    logic              busy;

    modport master (
        input  m_arvalid, m_ar_pld, m_rready, s_arready, s_rvalid, s_r_pld,
        output m_arready, m_rvalid, m_r_pld, s_arvalid, s_ar_pld, s_rready, gnt, busy
    );

    modport slave (
        output m_arvalid, m_ar_pld, m_rready, s_arready, s_rvalid, s_r_pld,
        input  m_arready, m_rvalid, m_r_pld, s_arvalid, s_ar_pld, s_rready, gnt, busy
    );
endinterface

// File: rtl/rvseed_arb_pick.sv
// rvseed_arb_pick: combinational two-way picker returning a one-hot winner.
// RVSEED_ARB_RR_EN defined: on contention the requester not granted last wins
// (ptr holds the last winner). Undefined: load (index 1) has fixed priority.

module rvseed_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);
`ifdef RVSEED_ARB_RR_EN
    // Alternate on contention, otherwise pass the single request through
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = ptr ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    // Load request always beats fetch
    always_comb begin
        win = 2'b00;
        if (req[1]) begin
            win = 2'b10;
        end else if (req[0]) begin
            win = 2'b01;
        end
    end
`endif
endmodule

// File: rtl/rvseed_rd_arb.sv
// rvseed_rd_arb: shares one AXI read port between fetch (0) and load (1).
// One transaction in flight; grant held from AR acceptance to the last R beat.
// RVSEED_ARB_RR_EN selects round-robin arbitration with a 1-bit last-winner pointer.

module rvseed_rd_arb
    import rvseed_rd_arb_pkg::*;
#(
    parameter int AR_PLD_W = `AXI_ID_WIDTH + `AXI_ADDR_WIDTH + `AXI_LEN_WIDTH + `AXI_SIZE_WIDTH + `AXI_BURST_WIDTH,
    parameter int R_PLD_W  = `AXI_ID_WIDTH + `AXI_DATA_WIDTH + `AXI_RESP_WIDTH + 1
) (
    input  logic            clk,
    input  logic            rst,
    rvseed_rd_arb_if.master bus
);
    arb_state_e            state;
    logic [1:0]            gnt_q;
    logic [AR_PLD_W-1:0]   ar_pld_q;
    logic                  ptr_q;
    logic [1:0]            win;
    logic                  win_idx;
    logic [AR_PLD_W-1:0]   win_pld;
    logic [R_PLD_W-1:0]    r_pld;
    logic                  r_last;
    logic                  r_hs;

    rvseed_arb_pick u_pick (
        .req (bus.m_arvalid),
        .ptr (ptr_q),
        .win (win)
    );

    assign win_idx = win[REQ_LSU];
    assign win_pld = win_idx ? bus.m_ar_pld[AR_PLD_W +: AR_PLD_W]
                             : bus.m_ar_pld[0 +: AR_PLD_W];

    assign r_pld  = bus.s_r_pld;
    assign r_last = r_pld[R_LAST_OFF];
    assign r_hs   = (state == DATA) && bus.s_rvalid && bus.s_rready;

    // Address accept is combinational in IDLE; routing afterwards follows gnt only
    assign bus.m_arready = (state == IDLE) ? win : 2'b00;
    assign bus.s_arvalid = (state == ADDR);
    assign bus.s_ar_pld  = ar_pld_q;
    assign bus.m_rvalid  = (state == DATA) ? (gnt_q & {2{bus.s_rvalid}}) : 2'b00;
    assign bus.s_rready  = (state == DATA) && (|(gnt_q & bus.m_rready));
    assign bus.m_r_pld   = r_pld;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state != IDLE);

`ifndef RVSEED_ARB_RR_EN
    assign ptr_q = 1'b0;
`endif

    // Transaction FSM: latch winner and payload in IDLE, release on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= 2'b00;
            ar_pld_q <= '0;
`ifdef RVSEED_ARB_RR_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|win) begin
                        ar_pld_q <= win_pld;
                        gnt_q    <= win;
                        state    <= ADDR;
`ifdef RVSEED_ARB_RR_EN
                        ptr_q    <= win_idx;
`endif
                    end
                end
                ADDR: begin
                    if (bus.s_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs && r_last) begin
                        gnt_q <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rvseed_rd_arb.sv
// tb_rvseed_rd_arb: scoreboard bench for rvseed_rd_arb.
// Stimulus pushes expected AR/R records into queues; a negedge monitor pops and compares.
// Expectations for the contention-after-load case follow RVSEED_ARB_RR_EN.

module tb_rvseed_rd_arb;
    import rvseed_rd_arb_pkg::*;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rvseed_rd_arb_if bus ();

    rvseed_rd_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [32:0] exp_ar[$];   // {requester, addr}
    logic [33:0] exp_r[$];    // {requester, last, data}

    int arr_cnt[2];
    int arr_cyc[2];
    int last_cyc[2];
    int r_seen = 0;

    int ar_dly    = 2;
    bit slave_en  = 1'b1;
    bit stray_rv  = 1'b0;
    bit rr_tog    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] mkdata(input logic [31:0] a, input int b);
        logic [7:0] bb;
        bb = 8'(b);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 8'hA5, bb};
    endfunction

    // Monitor: compares every AR handshake and every delivered R beat against the queues
    always @(negedge clk) begin
        logic [32:0] ea;
        logic [33:0] er;
        int idx;
        if (!rst) begin
            if (bus.m_arready != 2'b00) begin
                check("arready_onehot", 64'($onehot(bus.m_arready)), 64'd1);
                for (int i = 0; i < 2; i++) begin
                    if (bus.m_arready[i]) begin
                        arr_cnt[i]++;
                        arr_cyc[i] = cyc;
                    end
                end
            end
            if (bus.s_arvalid && bus.s_arready) begin
                if (exp_ar.size() == 0) begin
                    fail("ar_unexpected");
                end else begin
                    ea = exp_ar.pop_front();
                    check("ar_addr", 64'(bus.s_ar_pld[AR_ADDR_OFF +: 32]), 64'(ea[31:0]));
                    check("ar_gnt", 64'(bus.gnt), 64'(req_onehot(ea[32])));
                end
            end
            if (bus.m_rvalid != 2'b00) begin
                idx = bus.m_rvalid[1] ? 1 : 0;
                check("rready_mirror", 64'(bus.s_rready), 64'(bus.m_rready[idx]));
                if (bus.m_rready[idx]) begin
                    if (exp_r.size() == 0) begin
                        fail("r_unexpected");
                    end else begin
                        er = exp_r.pop_front();
                        check("r_owner", 64'(idx), 64'(er[33]));
                        check("r_data", 64'(bus.m_r_pld[R_DATA_OFF +: 32]), 64'(er[31:0]));
                        check("r_last", 64'(bus.m_r_pld[R_LAST_OFF]), 64'(er[32]));
                        check("r_gnt_held", 64'(bus.gnt), 64'(req_onehot(er[33])));
                    end
                    r_seen++;
                    if (bus.m_r_pld[R_LAST_OFF]) last_cyc[idx] = cyc;
                end
            end
        end
    end

    // Downstream slave: accepts AR after ar_dly cycles, then returns len+1 beats
    initial begin
        int sl;
        int cnt;
        int beat;
        int len;
        logic [31:0] addr;
        bit ar_hs;
        bit r_hs;
        bit seen;
        sl = 0; cnt = 0; beat = 0; len = 0; addr = '0;
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b0;
        bus.s_r_pld   = '0;
        forever begin
            @(negedge clk);
            ar_hs = bus.s_arvalid && bus.s_arready;
            r_hs  = bus.s_rvalid && bus.s_rready;
            seen  = bus.s_arvalid;
            if (ar_hs) begin
                addr = bus.s_ar_pld[AR_ADDR_OFF +: 32];
                len  = int'(bus.s_ar_pld[AR_LEN_OFF +: 8]);
            end
            @(posedge clk);
            #2;
            if (!slave_en) begin
                sl = 0;
                bus.s_arready = 1'b0;
                bus.s_rvalid  = stray_rv;
                bus.s_r_pld   = {{AXI_ID_W{1'b0}}, 32'h5555AAAA, 2'b00, 1'b1};
            end else begin
                case (sl)
                    0: begin
                        bus.s_arready = 1'b0;
                        bus.s_rvalid  = 1'b0;
                        if (seen) begin
                            if (ar_dly == 0) begin
                                bus.s_arready = 1'b1;
                                sl = 2;
                            end else begin
                                cnt = ar_dly - 1;
                                sl = 1;
                            end
                        end
                    end
                    1: begin
                        if (cnt == 0) begin
                            bus.s_arready = 1'b1;
                            sl = 2;
                        end else begin
                            cnt--;
                        end
                    end
                    2: begin
                        if (ar_hs) begin
                            bus.s_arready = 1'b0;
                            beat = 0;
                            bus.s_rvalid = 1'b1;
                            bus.s_r_pld = {{AXI_ID_W{1'b0}}, mkdata(addr, 0), 2'b00, (len == 0)};
                            sl = 3;
                        end
                    end
                    default: begin
                        if (r_hs) begin
                            if (beat == len) begin
                                bus.s_rvalid = 1'b0;
                                sl = 0;
                            end else begin
                                beat++;
                                bus.s_r_pld = {{AXI_ID_W{1'b0}}, mkdata(addr, beat), 2'b00, (beat == len)};
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Requester read-ready: all ones, or toggling when rr_tog is set
    initial begin
        bit ph;
        ph = 1'b0;
        bus.m_rready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            if (rr_tog) begin
                ph = ~ph;
                bus.m_rready = {2{ph}};
            end else begin
                ph = 1'b0;
                bus.m_rready = 2'b11;
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] addr, input logic [7:0] len);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.m_arvalid[i] = 1'b1;
        bus.m_ar_pld[i*AR_PLD_W +: AR_PLD_W] = {{AXI_ID_W{1'b0}}, addr, len, 3'd2, 2'd1};
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (bus.m_arready[i]) got = 1'b1;
        end
        if (!got) fail("ar_accept_timeout");
        @(posedge clk);
        #1;
        bus.m_arvalid[i] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (exp_ar.size() == 0 && exp_r.size() == 0 && !bus.busy) ok = 1'b1;
        end
        check({nm, "_done"}, 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_m_arready"}, 64'(bus.m_arready), 64'd0);
        check({nm, "_s_arvalid"}, 64'(bus.s_arvalid), 64'd0);
        check({nm, "_s_ar_pld"},  64'(bus.s_ar_pld),  64'd0);
        check({nm, "_m_rvalid"},  64'(bus.m_rvalid),  64'd0);
        check({nm, "_s_rready"},  64'(bus.s_rready),  64'd0);
        check({nm, "_gnt"},       64'(bus.gnt),       64'd0);
        check({nm, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    // Directed sequence
    initial begin
        int a0;
        int rs;
        bit got;
        arr_cnt[0] = 0; arr_cnt[1] = 0;
        arr_cyc[0] = 0; arr_cyc[1] = 0;
        last_cyc[0] = 0; last_cyc[1] = 0;
        bus.m_arvalid = 2'b00;
        bus.m_ar_pld  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch only, single beat, AR accepted after 2 cycles
        ar_dly = 2;
        exp_ar.push_back({1'b0, 32'h0000_0100});
        exp_r.push_back({1'b0, 1'b1, 32'hDEADBEEF});
        a0 = arr_cnt[0];
        issue(0, 32'h100, 8'd0);
        wait_idle("fetch_only");
        check("fetch_arready_pulses", 64'(arr_cnt[0] - a0), 64'd1);
        check("fetch_gnt_clear", 64'(bus.gnt), 64'd0);

        // Simultaneous requests: load first, fetch granted the cycle after load's last beat
        ar_dly = 0;
        exp_ar.push_back({1'b1, 32'h0000_0300});
        exp_r.push_back({1'b1, 1'b1, 32'h0300_A500});
        exp_ar.push_back({1'b0, 32'h0000_0200});
        exp_r.push_back({1'b0, 1'b1, 32'h0200_A500});
        fork
            issue(0, 32'h200, 8'd0);
            issue(1, 32'h300, 8'd0);
        join
        wait_idle("contend");
        check("b2b_gap", 64'(arr_cyc[0] - last_cyc[1]), 64'd1);

        // Contention right after a load-only grant
        exp_ar.push_back({1'b1, 32'h0000_0600});
        exp_r.push_back({1'b1, 1'b1, 32'h0600_A500});
        issue(1, 32'h600, 8'd0);
        wait_idle("load_only");
`ifdef RVSEED_ARB_RR_EN
        exp_ar.push_back({1'b0, 32'h0000_0200});
        exp_r.push_back({1'b0, 1'b1, 32'h0200_A500});
        exp_ar.push_back({1'b1, 32'h0000_0300});
        exp_r.push_back({1'b1, 1'b1, 32'h0300_A500});
`else
        exp_ar.push_back({1'b1, 32'h0000_0300});
        exp_r.push_back({1'b1, 1'b1, 32'h0300_A500});
        exp_ar.push_back({1'b0, 32'h0000_0200});
        exp_r.push_back({1'b0, 1'b1, 32'h0200_A500});
`endif
        fork
            issue(0, 32'h200, 8'd0);
            issue(1, 32'h300, 8'd0);
        join
        wait_idle("contend_after_load");
`ifdef RVSEED_ARB_RR_EN
        check("rr_gap", 64'(arr_cyc[1] - last_cyc[0]), 64'd1);
`else
        check("fixed_gap", 64'(arr_cyc[0] - last_cyc[1]), 64'd1);
`endif

        // Burst of 4 beats with toggling m_rready
        ar_dly = 1;
        rr_tog = 1'b1;
        rs = r_seen;
        exp_ar.push_back({1'b1, 32'h0000_0500});
        exp_r.push_back({1'b1, 1'b0, 32'h0500_A500});
        exp_r.push_back({1'b1, 1'b0, 32'h0500_A501});
        exp_r.push_back({1'b1, 1'b0, 32'h0500_A502});
        exp_r.push_back({1'b1, 1'b1, 32'h0500_A503});
        issue(1, 32'h500, 8'd3);
        wait_idle("burst");
        check("burst_beats", 64'(r_seen - rs), 64'd4);
        rr_tog = 1'b0;

        // Stray downstream s_rvalid while idle
        @(posedge clk);
        #1;
        slave_en = 1'b0;
        stray_rv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_s_rready", 64'(bus.s_rready), 64'd0);
            check("stray_m_rvalid", 64'(bus.m_rvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        slave_en = 1'b1;

        // Reset during DATA after the first of four beats
        ar_dly = 0;
        rs = r_seen;
        exp_ar.push_back({1'b0, 32'h0000_0400});
        exp_r.push_back({1'b0, 1'b0, 32'h0400_A500});
        issue(0, 32'h400, 8'd3);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            if (r_seen > rs) got = 1'b1;
        end
        if (!got) fail("first_beat_timeout");
        #1;
        rst = 1'b1;
        slave_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        slave_en = 1'b1;
        exp_ar.push_back({1'b1, 32'h0000_0700});
        exp_r.push_back({1'b1, 1'b1, 32'h0700_A500});
        bus.m_arvalid[1] = 1'b1;
        bus.m_ar_pld[AR_PLD_W +: AR_PLD_W] = {{AXI_ID_W{1'b0}}, 32'h700, 8'd0, 3'd2, 2'd1};
        @(negedge clk);
        check("post_rst_accept", 64'(bus.m_arready), 64'h2);
        @(posedge clk);
        #1;
        bus.m_arvalid[1] = 1'b0;
        wait_idle("post_rst");
        check("post_rst_gnt_clear", 64'(bus.gnt), 64'd0);

        check("queues_drained", 64'(exp_ar.size() + exp_r.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end
endmodule
